tls_multi_phase: RTL and testbench
==================================

Name: tls_multi_phase

Overview:
- Parametrised N-phase traffic light controller; successor to the single-approach G/Y/R controller.
- Runs enabled phases round-robin: GREEN -> YELLOW -> ALL-RED clearance -> next enabled phase.
- Per-phase green/yellow times and a shared all-red time are runtime-programmable. Supports hold, green preemption and restart.
- Outputs drive the lamp drivers directly; red is the fail-safe state.

Parameters:
- NUM_PHASES, 4, number of signal phases (2..8).
- TW, 8, width of every duration field and of the interval counter.
- DEF_G, 8'd10, reset green time of every phase.
- DEF_Y, 8'd3, reset yellow time of every phase.
- DEF_AR, 8'd2, reset all-red clearance time.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  write cfg_g/cfg_y into table entry cfg_phase; write cfg_ar
- cfg_phase  in  clog2(NUM_PHASES)  table index for cfg_we
- cfg_g  in  TW  green time in cycles; 0 = phase disabled
- cfg_y  in  TW  yellow time in cycles
- cfg_ar  in  TW  all-red time in cycles (shared)
- restart  in  1  synchronous restart of the sequence
- hold  in  1  freeze current interval
- preempt  in  1  end current green early
- green  out  NUM_PHASES  green lamp per phase
- yellow  out  NUM_PHASES  yellow lamp per phase
- red  out  NUM_PHASES  red lamp per phase
- cur_phase  out  clog2(NUM_PHASES)  active phase index
- phase_start  out  1  one-cycle pulse on the first GREEN cycle of any phase

Behaviour:
- Reset values:
  - state = ALLRED, cur_phase = NUM_PHASES-1, cnt = 1, dur = DEF_AR.
  - Table: all phases DEF_G/DEF_Y; ar = DEF_AR.
  - Outputs: green = 0, yellow = 0, red = all ones, phase_start = 0.
- States are ALLRED, GREEN and YELLOW, held in a register; lamps are decoded combinationally from state and cur_phase.
  - GREEN: green[cur_phase] = 1, red = all ones except cur_phase.
  - YELLOW: yellow[cur_phase] = 1, red = all ones except cur_phase.
  - ALLRED: red = all ones. At most one green or yellow bit is set at any time.
- Duration latch: on entry to any state, dur <= table value for that state, evaluated in the entry cycle. A value of 0 for yellow or all-red is treated as 1. cnt <= 1 on entry.
- Interval: a state lasts exactly dur cycles absent hold or preempt. Exit when cnt >= dur; otherwise cnt <= cnt + 1.
- Transitions:
  - GREEN -> YELLOW (same phase).
  - YELLOW -> ALLRED.
  - ALLRED -> GREEN of the next enabled phase: search cur_phase+1, +2, ... with wrap NUM_PHASES-1 -> 0. The search includes cur_phase itself last, so a single enabled phase repeats.
  - If no phase is enabled, remain in ALLRED and reload cnt = 1 every ar cycles. cur_phase is unchanged.
- phase_start is registered and asserted for the first GREEN cycle.
- Priority per cycle: restart > preempt > hold > timer.
  - restart: state <= ALLRED, cur_phase <= NUM_PHASES-1, cnt <= 1, dur <= ar. The table is not modified.
  - preempt: acts in GREEN only, forcing YELLOW next cycle regardless of cnt. Ignored in YELLOW/ALLRED, where it has no effect and hold still applies.
  - hold: cnt and state frozen, including at the expiry cycle; lamps unchanged.
- Configuration:
  - cfg_we writes the table in the same cycle.
  - A write never alters the interval in progress; the new value is used at the next entry to that state.
  - A write in the same cycle as a state entry is seen by that entry (write-through).
  - Writing cfg_g = 0 to the active phase lets its current green finish, and skips the phase afterwards.
- Width rules: cnt is TW bits and never wraps, because exit occurs at cnt = dur <= 2^TW-1.
- Reset mid-interval returns immediately to the reset values; no lamp glitch beyond the asynchronous transition to all red.

Test Plan:
- Defaults, N=4, no inputs after reset -> ALLRED 2 cycles, then phase 0 G 10, Y 3, AR 2, then phase 1 G. phase_start pulses at cycle 2 and cycle 17 after reset release.
- Write cfg_g = 0 for phases 1 and 2 during phase 0 green -> sequence goes phase 0 -> 3 -> 0. cur_phase never equals 1 or 2.
- hold high for 5 cycles at the last green cycle of phase 0 -> green lasts 15 cycles total, then yellow 3.
- preempt pulse at green cycle 4 of phase 0 -> yellow[0] on the next cycle, lasting 3. preempt asserted during YELLOW -> no effect.
- All cfg_g = 0 -> red = 4'b1111 indefinitely. Then set cfg_g = 5 for phase 2 -> after the current AR completes, green[2] for 5 cycles, repeating.
- Assert reset mid-YELLOW, and separately restart concurrent with preempt and hold -> all red, cur_phase = 3, first green is phase 0 after an AR of 2 cycles. restart wins.

Source files
------------

// File: rtl/tls_multi_phase.sv
// N-phase round-robin traffic light controller: GREEN -> YELLOW -> ALL-RED -> next enabled phase.
// Durations are runtime-programmable per phase; red is the fail-safe lamp state.
module tls_multi_phase #(
    parameter int              NUM_PHASES = 4,
    parameter int              TW         = 8,
    parameter logic [TW-1:0]   DEF_G      = TW'(10),
    parameter logic [TW-1:0]   DEF_Y      = TW'(3),
    parameter logic [TW-1:0]   DEF_AR     = TW'(2),
    localparam int             PW         = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [PW-1:0]         cfg_phase,
    input  logic [TW-1:0]         cfg_g,
    input  logic [TW-1:0]         cfg_y,
    input  logic [TW-1:0]         cfg_ar,
    input  logic                  restart,
    input  logic                  hold,
    input  logic                  preempt,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [PW-1:0]         cur_phase,
    output logic                  phase_start
);

    typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW} state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_cur_phase, w_phase_next;
    logic [TW-1:0]   r_cnt, w_cnt_next;
    logic [TW-1:0]   r_dur, w_dur_next;
    logic            r_phase_start, w_start_next;

    logic [TW-1:0]   r_g [NUM_PHASES];
    logic [TW-1:0]   r_y [NUM_PHASES];
    logic [TW-1:0]   r_ar;

    logic [TW-1:0]   w_g_eff [NUM_PHASES];
    logic [TW-1:0]   w_y_eff [NUM_PHASES];
    logic [TW-1:0]   w_ar_eff;
    logic [NUM_PHASES-1:0] w_en;
    logic            w_found;
    logic [PW-1:0]   w_next_phase;
    logic [PW-1:0]   w_cand;

    function automatic logic [TW-1:0] min1(input logic [TW-1:0] v);
        return (v == '0) ? TW'(1) : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                r_g[i] <= DEF_G;
                r_y[i] <= DEF_Y;
            end
            r_ar <= DEF_AR;
        end else if (cfg_we) begin
            r_g[cfg_phase] <= cfg_g;
            r_y[cfg_phase] <= cfg_y;
            r_ar           <= cfg_ar;
        end
    end

    // Write-through view so an entry in the same cycle as a write sees the new value.
    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_eff
            assign w_g_eff[gi] = (cfg_we && cfg_phase == PW'(gi)) ? cfg_g : r_g[gi];
            assign w_y_eff[gi] = (cfg_we && cfg_phase == PW'(gi)) ? cfg_y : r_y[gi];
            assign w_en[gi]    = (w_g_eff[gi] != '0);
        end
    endgenerate
    assign w_ar_eff = cfg_we ? cfg_ar : r_ar;

    // Round-robin search starting after cur_phase; cur_phase itself is tried last.
    always_comb begin
        w_found      = 1'b0;
        w_next_phase = r_cur_phase;
        w_cand       = '0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            w_cand = PW'((int'(r_cur_phase) + k) % NUM_PHASES);
            if (!w_found && w_en[w_cand]) begin
                w_found      = 1'b1;
                w_next_phase = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_cur_phase;
        w_cnt_next   = r_cnt;
        w_dur_next   = r_dur;
        w_start_next = 1'b0;
        if (restart) begin
            w_state_next = ST_ALLRED;
            w_phase_next = PW'(NUM_PHASES - 1);
            w_cnt_next   = TW'(1);
            w_dur_next   = w_ar_eff;
        end else if (preempt && r_state == ST_GREEN) begin
            w_state_next = ST_YELLOW;
            w_cnt_next   = TW'(1);
            w_dur_next   = min1(w_y_eff[r_cur_phase]);
        end else if (!hold) begin
            if (r_cnt < r_dur) begin
                w_cnt_next = r_cnt + TW'(1);
            end else begin
                w_cnt_next = TW'(1);
                case (r_state)
                    ST_GREEN: begin
                        w_state_next = ST_YELLOW;
                        w_dur_next   = min1(w_y_eff[r_cur_phase]);
                    end
                    ST_YELLOW: begin
                        w_state_next = ST_ALLRED;
                        w_dur_next   = min1(w_ar_eff);
                    end
                    default: begin
                        w_state_next = ST_ALLRED;
                        w_dur_next   = min1(w_ar_eff);
                        if (w_found) begin
                            w_state_next = ST_GREEN;
                            w_phase_next = w_next_phase;
                            w_dur_next   = w_g_eff[w_next_phase];
                            w_start_next = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ALLRED;
            r_cur_phase   <= PW'(NUM_PHASES - 1);
            r_cnt         <= TW'(1);
            r_dur         <= DEF_AR;
            r_phase_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cur_phase   <= w_phase_next;
            r_cnt         <= w_cnt_next;
            r_dur         <= w_dur_next;
            r_phase_start <= w_start_next;
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        case (r_state)
            ST_GREEN: begin
                green[r_cur_phase] = 1'b1;
                red[r_cur_phase]   = 1'b0;
            end
            ST_YELLOW: begin
                yellow[r_cur_phase] = 1'b1;
                red[r_cur_phase]    = 1'b0;
            end
            default: ;
        endcase
    end

    assign cur_phase   = r_cur_phase;
    assign phase_start = r_phase_start;

endmodule

// File: tb/tb_tls_multi_phase.sv
// Directed and random stimulus for tls_multi_phase, checked every cycle against a
// countdown-based behavioural model of the light sequence.
module tb_tls_multi_phase;

    localparam int N = 4;
    localparam int M_AR = 0, M_G = 1, M_Y = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_phase;
    logic [7:0] cfg_g, cfg_y, cfg_ar;
    logic       restart, hold, preempt;
    logic [3:0] green, yellow, red;
    logic [1:0] cur_phase;
    logic       phase_start;

    int total = 0;
    int bad   = 0;

    // model: remaining cycles of the current interval instead of an up-counter
    int m_mode, m_ph, m_rem;
    bit m_start;
    int m_g [N];
    int m_y [N];
    int m_ar;

    tls_multi_phase dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_phase(cfg_phase),
        .cfg_g(cfg_g), .cfg_y(cfg_y), .cfg_ar(cfg_ar), .restart(restart),
        .hold(hold), .preempt(preempt), .green(green), .yellow(yellow),
        .red(red), .cur_phase(cur_phase), .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_mode = M_AR; m_ph = N - 1; m_rem = 2; m_start = 0;
        for (int i = 0; i < N; i++) begin m_g[i] = 10; m_y[i] = 3; end
        m_ar = 2;
    endtask

    task automatic model_step();
        bit found;
        if (cfg_we) begin
            m_g[cfg_phase] = cfg_g; m_y[cfg_phase] = cfg_y; m_ar = cfg_ar;
        end
        m_start = 0;
        if (restart) begin
            m_mode = M_AR; m_ph = N - 1; m_rem = max1(m_ar);
        end else if (preempt && m_mode == M_G) begin
            m_mode = M_Y; m_rem = max1(m_y[m_ph]);
        end else if (!hold) begin
            if (m_rem > 1) m_rem--;
            else if (m_mode == M_G) begin m_mode = M_Y; m_rem = max1(m_y[m_ph]); end
            else if (m_mode == M_Y) begin m_mode = M_AR; m_rem = max1(m_ar); end
            else begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && m_g[(m_ph + k) % N] != 0) begin
                        found = 1; m_ph = (m_ph + k) % N;
                    end
                end
                if (found) begin m_mode = M_G; m_rem = m_g[m_ph]; m_start = 1; end
                else m_rem = max1(m_ar);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, ey;
        eg = (m_mode == M_G) ? (4'b0001 << m_ph) : 4'b0000;
        ey = (m_mode == M_Y) ? (4'b0001 << m_ph) : 4'b0000;
        check("green", 32'(green), 32'(eg));
        check("yellow", 32'(yellow), 32'(ey));
        check("red", 32'(red), 32'(4'hF & ~(eg | ey)));
        check("cur_phase", 32'(cur_phase), 32'(m_ph));
        check("phase_start", 32'(phase_start), 32'(m_start));
    endtask

    task automatic tick(input bit rs, input bit hd, input bit pe, input bit we,
                        input int ph, input int g, input int y, input int ar);
        restart = rs; hold = hd; preempt = pe; cfg_we = we;
        cfg_phase = 2'(ph); cfg_g = 8'(g); cfg_y = 8'(y); cfg_ar = 8'(ar);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ps_idx [$];
        int gcnt, ycnt;
        bit saw12, saw3, lamp_on;

        reset = 1; restart = 0; hold = 0; preempt = 0; cfg_we = 0;
        cfg_phase = 0; cfg_g = 0; cfg_y = 0; cfg_ar = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check("reset_red", 32'(red), 32'h0000_000F);
        reset = 0;

        $display("step: defaults after reset");
        for (int t = 0; t < 20; t++) begin
            idle(1);
            if (phase_start) ps_idx.push_back(t);
        end
        check("ps_count", 32'(ps_idx.size()), 32'd2);
        if (ps_idx.size() >= 2) begin
            check("ps_first", 32'(ps_idx[0]), 32'd1);
            check("ps_second", 32'(ps_idx[1]), 32'd16);
        end

        $display("step: disable phases 1 and 2 during phase 0 green");
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        tick(0, 0, 0, 1, 1, 0, 3, 2);
        tick(0, 0, 0, 1, 2, 0, 3, 2);
        saw12 = 0; saw3 = 0;
        for (int t = 0; t < 60; t++) begin
            idle(1);
            if (cur_phase == 2'd1 || cur_phase == 2'd2) saw12 = 1;
            if (cur_phase == 2'd3) saw3 = 1;
        end
        check("skip12", 32'(saw12), 32'd0);
        check("visit3", 32'(saw3), 32'd1);
        tick(0, 0, 0, 1, 1, 10, 3, 2);
        tick(0, 0, 0, 1, 2, 10, 3, 2);

        $display("step: hold 5 cycles at last green cycle of phase 0");
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        gcnt = 0; ycnt = 0;
        for (int t = 1; t <= 30; t++) begin
            tick(0, (t >= 12 && t <= 16), 0, 0, 0, 0, 0, 0);
            if (green[0]) gcnt++;
            if (yellow[0]) ycnt++;
        end
        check("hold_green_len", 32'(gcnt), 32'd15);
        check("hold_yellow_len", 32'(ycnt), 32'd3);

        $display("step: preempt at green cycle 4, then during yellow");
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        gcnt = 0; ycnt = 0;
        for (int t = 1; t <= 20; t++) begin
            tick(0, 0, (t == 6 || t == 7), 0, 0, 0, 0, 0);
            if (green[0]) gcnt++;
            if (yellow[0]) ycnt++;
        end
        check("pre_green_len", 32'(gcnt), 32'd4);
        check("pre_yellow_len", 32'(ycnt), 32'd3);

        $display("step: all phases disabled, then enable phase 2 with g=5");
        for (int p = 0; p < N; p++) tick(0, 0, 0, 1, p, 0, 3, 2);
        idle(20);
        lamp_on = 0;
        for (int t = 0; t < 30; t++) begin
            idle(1);
            if (red != 4'hF) lamp_on = 1;
        end
        check("all_disabled_red", 32'(lamp_on), 32'd0);
        tick(0, 0, 0, 1, 2, 5, 3, 2);
        gcnt = 0;
        for (int t = 0; t < 30; t++) begin
            idle(1);
            if (green[2]) gcnt++;
        end
        check("p2_green_cycles", 32'(gcnt >= 10), 32'd1);
        for (int p = 0; p < N; p++) tick(0, 0, 0, 1, p, 10, 3, 2);

        $display("step: asynchronous reset mid-yellow");
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        idle(12);
        check("in_yellow", 32'(yellow[0]), 32'd1);
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 0;
        check_all();
        idle(16);

        $display("step: restart with preempt and hold");
        idle(4);
        tick(1, 1, 1, 0, 0, 0, 0, 0);
        idle(16);

        $display("step: random traffic");
        for (int t = 0; t < 600; t++) begin
            tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
